// File: rtl/hex_scan_mux.sv
// Time-multiplexed four-digit hex display scanner with a one-clock blanking gap between digits.
// Optional leading-zero blanking is compiled in when HEX_SCAN_LZB_EN is defined.
module hex_scan_mux #(
    parameter int unsigned DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic [1:0]  digit
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

    typedef enum logic [0:0] {StScan, StDead} state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  hex_q, hex_d;
    logic [3:0]  an_q, an_d;
    logic        tick;
    logic        blank;

    assign tick = en && (cnt_q == CntMax);

    always_comb begin
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        state_d  = state_q;
        shadow_d = load ? value : shadow_q;
        hex_d    = hex_q;
        an_d     = 4'b1111;
        blank    = 1'b0;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                StScan: begin
                    if (tick) begin
                        digit_d = digit_q + 2'd1;
                        state_d = StDead;
                    end
                end
                StDead: state_d = StScan;
                default: state_d = StScan;
            endcase
            hex_d = shadow_q[{digit_q, 2'b00} +: 4];
        end

`ifdef HEX_SCAN_LZB_EN
        // A digit is dark when it and every more-significant nibble are zero.
        unique case (digit_d)
            2'd1: blank = (shadow_d[15:4] == 12'h000);
            2'd2: blank = (shadow_d[15:8] == 8'h00);
            2'd3: blank = (shadow_d[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        // an is registered from next-state so it tracks the FSM without a cycle of lag.
        if (en && (state_d == StScan) && !blank) begin
            an_d = ~(4'b0001 << digit_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            digit_q  <= 2'd0;
            state_q  <= StScan;
            shadow_q <= 16'h0000;
            hex_q    <= 4'h0;
            an_q     <= 4'b1111;
        end else begin
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            hex_q    <= hex_d;
            an_q     <= an_d;
        end
    end

    assign hex   = hex_q;
    assign an    = an_q;
    assign digit = digit_q;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Self-checking bench for hex_scan_mux (DIV=4): per-slot scoreboard of digit, hex, an,
// lit length and dark gap, compared as each lit slot completes.
`timescale 1ns/1ps
module tb_hex_scan_mux;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] value;
    logic [3:0]  hex, an;
    logic [1:0]  digit;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] d;
        logic [3:0] h;
        logic [3:0] a;
        int         len;
        int         gap;  // -1 when the preceding gap is not checked
    } slot_t;

    slot_t sb[$];

    hex_scan_mux #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .value (value),
        .hex   (hex),
        .an    (an),
        .digit (digit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic slot_t mk(input logic [1:0] d, input logic [3:0] h,
                                 input logic [3:0] a, input int len, input int gap);
        slot_t s;
        s.d = d; s.h = h; s.a = a; s.len = len; s.gap = gap;
        return s;
    endfunction

    // Observe n lit slots starting at the current negedge sample and check each against sb.
    task automatic run_slots(input int n);
        int gap, len;
        logic [1:0] d;
        logic [3:0] h, a;
        slot_t e;
        gap = 0;
        for (int s = 0; s < n; s++) begin
            e = sb.pop_front();
            while (an === 4'b1111 && gap < 200) begin
                gap++;
                @(negedge clk);
            end
            tests++;
            if (gap >= 200) begin
                fails++;
                $display("FAIL slot_timeout: no lit digit seen, gap=%0d, expected digit %0d", gap, e.d);
                return;
            end
            len = 0;
            d = 'x; h = 'x; a = 'x;
            while (an !== 4'b1111 && len < 200) begin
                len++;
                d = digit; h = hex; a = an;
                @(negedge clk);
            end
            tests++;
            if (d !== e.d) begin
                fails++;
                $display("FAIL slot_digit: got %0d, expected %0d", d, e.d);
            end
            tests++;
            if (h !== e.h) begin
                fails++;
                $display("FAIL slot_hex: digit %0d got %h, expected %h", e.d, h, e.h);
            end
            tests++;
            if (a !== e.a) begin
                fails++;
                $display("FAIL slot_an: digit %0d got %b, expected %b", e.d, a, e.a);
            end
            tests++;
            if (len !== e.len) begin
                fails++;
                $display("FAIL slot_len: digit %0d lit %0d clocks, expected %0d", e.d, len, e.len);
            end
            if (e.gap >= 0) begin
                tests++;
                if (gap !== e.gap) begin
                    fails++;
                    $display("FAIL slot_gap: before digit %0d dark %0d clocks, expected %0d",
                             e.d, gap, e.gap);
                end
            end
            gap = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; value = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (an !== 4'b1111 || digit !== 2'd0 || hex !== 4'h0) begin
                fails++;
                $display("FAIL reset_state: an=%b digit=%0d hex=%h, expected 1111 0 0", an, digit, hex);
            end
        end
        rst = 1'b0; load = 1'b1; value = 16'hA3F1;
        @(negedge clk);
        load = 1'b0;
        tests++;
        if (an !== 4'b1110) begin
            fails++;
            $display("FAIL reset_first_an: got %b, expected 1110", an);
        end
        tests++;
        if (digit !== 2'd0) begin
            fails++;
            $display("FAIL reset_first_digit: got %0d, expected 0", digit);
        end
    endtask

    task automatic test_scan();
        sb.push_back(mk(2'd0, 4'h1, 4'b1110, 3, -1));
        sb.push_back(mk(2'd1, 4'hF, 4'b1101, 3, 1));
        sb.push_back(mk(2'd2, 4'h3, 4'b1011, 3, 1));
        sb.push_back(mk(2'd3, 4'hA, 4'b0111, 3, 1));
        sb.push_back(mk(2'd0, 4'h1, 4'b1110, 3, 1));
        run_slots(5);
    endtask

    task automatic test_load_tick();
        int w, lit;
        w = 0;
        while (an === 4'b1111 && w < 50) begin w++; @(negedge clk); end
        tests++;
        if (digit !== 2'd1) begin
            fails++;
            $display("FAIL load_tick_pre_digit: got %0d, expected 1", digit);
        end
        lit = 1;
        while (lit < 3 && w < 50) begin w++; lit++; @(negedge clk); end
        // Next rising edge is the slot-ending tick.
        load = 1'b1; value = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        sb.push_back(mk(2'd2, 4'h2, 4'b1011, 3, -1));
        sb.push_back(mk(2'd3, 4'h1, 4'b0111, 3, 1));
        run_slots(2);
    endtask

    task automatic test_stall();
        int w;
        w = 0;
        while (an === 4'b1111 && w < 50) begin w++; @(negedge clk); end
        tests++;
        if (digit !== 2'd0 || an !== 4'b1110) begin
            fails++;
            $display("FAIL stall_pre: digit=%0d an=%b, expected 0 1110", digit, an);
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (an !== 4'b1111 || digit !== 2'd0 || hex !== 4'h4) begin
                fails++;
                $display("FAIL stall_hold: cycle %0d an=%b digit=%0d hex=%h, expected 1111 0 4",
                         i, an, digit, hex);
            end
        end
        en = 1'b1;
        sb.push_back(mk(2'd0, 4'h4, 4'b1110, 2, -1));
        sb.push_back(mk(2'd1, 4'h3, 4'b1101, 3, 1));
        run_slots(2);
    endtask

    task automatic test_reset_dead();
        tests++;
        if (digit !== 2'd2 || an !== 4'b1111) begin
            fails++;
            $display("FAIL rst_dead_pre: digit=%0d an=%b, expected 2 1111", digit, an);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (digit !== 2'd0 || an !== 4'b1111 || hex !== 4'h0) begin
            fails++;
            $display("FAIL rst_dead_state: digit=%0d an=%b hex=%h, expected 0 1111 0", digit, an, hex);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (an !== 4'b1110 || digit !== 2'd0) begin
            fails++;
            $display("FAIL rst_dead_release: an=%b digit=%0d, expected 1110 0", an, digit);
        end
        // Shadow was cleared, so every nibble reads back as zero.
        sb.push_back(mk(2'd0, 4'h0, 4'b1110, 3, -1));
        sb.push_back(mk(2'd1, 4'h0, 4'b1101, 3, 1));
        run_slots(2);
    endtask

    task automatic load_now(input logic [15:0] v);
        load = 1'b1; value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_blanking();
        load_now(16'h0007);
`ifdef HEX_SCAN_LZB_EN
        sb.push_back(mk(2'd0, 4'h7, 4'b1110, 3, -1));
        sb.push_back(mk(2'd0, 4'h7, 4'b1110, 3, 13));
        run_slots(2);
        load_now(16'h0000);
        sb.push_back(mk(2'd0, 4'h0, 4'b1110, 3, -1));
        sb.push_back(mk(2'd0, 4'h0, 4'b1110, 3, 13));
        run_slots(2);
`else
        sb.push_back(mk(2'd2, 4'h0, 4'b1011, 3, -1));
        sb.push_back(mk(2'd3, 4'h0, 4'b0111, 3, 1));
        sb.push_back(mk(2'd0, 4'h7, 4'b1110, 3, 1));
        sb.push_back(mk(2'd1, 4'h0, 4'b1101, 3, 1));
        run_slots(4);
        load_now(16'h0000);
        sb.push_back(mk(2'd2, 4'h0, 4'b1011, 3, -1));
        sb.push_back(mk(2'd3, 4'h0, 4'b0111, 3, 1));
        sb.push_back(mk(2'd0, 4'h0, 4'b1110, 3, 1));
        run_slots(3);
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0000;
        test_reset();
        test_scan();
        test_load_tick();
        test_stall();
        test_reset_dead();
        test_blanking();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
